// File: rtl/safety_island_pkg.sv
// safety_island_pkg: shared types for the lockstep supervisor
package safety_island_pkg;
  typedef enum logic [1:0] {LsRun, LsHalt, LsResync, LsFatal} lockstep_state_e;
endpackage

// File: rtl/safety_tmr_voter.sv
// safety_tmr_voter: bitwise majority or core-0 pass-through vote, per-core disagreement and uncorrectable flag
module safety_tmr_voter #(
  parameter int NumCores    = 3,
  parameter int BundleWidth = 72
) (
  input  logic [NumCores-1:0][BundleWidth-1:0] core_out_i,
  input  logic                                 vote_en_i,
  input  logic                                 dmr_i,
  output logic [BundleWidth-1:0]               voted_o,
  output logic [NumCores-1:0]                  diff_o,
  output logic                                 uncorr_o
);
  logic [BundleWidth-1:0] maj;
  if (NumCores == 3) begin : g_tmr
    assign maj = (core_out_i[0] & core_out_i[1]) | (core_out_i[0] & core_out_i[2]) |
                 (core_out_i[1] & core_out_i[2]);
  end else begin : g_dmr
    assign maj = core_out_i[0];
  end
  assign voted_o = (vote_en_i && !dmr_i) ? maj : core_out_i[0];
  // in detect-only mode a third core is a spectator and never flagged
  for (genvar i = 0; i < NumCores; i++) begin : g_diff
    assign diff_o[i] = |(core_out_i[i] ^ voted_o) && !(dmr_i && i > 1);
  end
  assign uncorr_o = dmr_i ? |diff_o : $countones(diff_o) > 1;
endmodule

// File: rtl/safety_lockstep_ctrl.sv
// safety_lockstep_ctrl: lockstep supervisor voting redundant core bundles and sequencing halt/drain/resync recovery
module safety_lockstep_ctrl #(
  parameter int NumCores      = 3,
  parameter int BundleWidth   = 72,
  parameter int DrainCycles   = 8,
  parameter int ResyncTimeout = 256,
  parameter int CntWidth      = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 enable_i,
  input  logic                                 dmr_mode_i,
  input  logic                                 clear_i,
  input  logic [NumCores-1:0][BundleWidth-1:0] core_out_i,
  output logic [BundleWidth-1:0]               voted_out_o,
  output logic                                 halt_o,
  output logic                                 resync_req_o,
  input  logic                                 resync_ack_i,
  output logic [NumCores-1:0]                  mismatch_o,
  output logic                                 fault_o,
  output logic [CntWidth-1:0]                  err_cnt_o
);
  import safety_island_pkg::*;
  localparam int DrainW = $clog2(DrainCycles + 1);
  localparam int TmoW   = $clog2(ResyncTimeout + 1);
  if (NumCores != 2 && NumCores != 3) begin : g_bad_cores
    $error("safety_lockstep_ctrl: NumCores must be 2 or 3");
  end
  lockstep_state_e       state_q, state_d;
  logic [DrainW-1:0]     drain_q, drain_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [NumCores-1:0]   mis_q, mis_d, diff;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  halt_q, req_q, fault_q, dmr, uncorr;
  assign dmr = NumCores == 2 || dmr_mode_i;
  safety_tmr_voter #(.NumCores(NumCores), .BundleWidth(BundleWidth)) u_voter (
    .core_out_i(core_out_i),
    .vote_en_i (enable_i),
    .dmr_i     (dmr),
    .voted_o   (voted_out_o),
    .diff_o    (diff),
    .uncorr_o  (uncorr)
  );
  // clear applies first so a same-cycle event lands on zeroed flags/counter
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    tmo_d   = tmo_q;
    mis_d   = clear_i ? '0 : mis_q;
    cnt_d   = clear_i ? '0 : cnt_q;
    if (enable_i) begin
      case (state_q)
        LsRun: if (|diff) begin
          mis_d   = mis_d | diff;
          cnt_d   = &cnt_d ? cnt_d : cnt_d + 1'b1;
          drain_d = DrainW'(DrainCycles - 1);
          state_d = uncorr ? LsFatal : LsHalt;
        end
        LsHalt: begin
          state_d = uncorr ? LsFatal : (drain_q == '0 ? LsResync : LsHalt);
          drain_d = drain_q - 1'b1;
          tmo_d   = '0;
        end
        LsResync: begin
          state_d = resync_ack_i ? LsRun : (tmo_q == TmoW'(ResyncTimeout - 1) ? LsFatal : LsResync);
          tmo_d   = tmo_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LsRun;
      drain_q <= '0;
      tmo_q   <= '0;
      mis_q   <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      tmo_q   <= tmo_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
      halt_q  <= state_d != LsRun;
      req_q   <= state_d == LsResync;
      fault_q <= state_d == LsFatal;
    end
  end
  assign halt_o       = halt_q;
  assign resync_req_o = req_q;
  assign fault_o      = fault_q;
  assign mismatch_o   = mis_q;
  assign err_cnt_o    = cnt_q;
endmodule
